// File: rtl/bnn_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pkg
//   Shared definitions for the BNN classifier result reporter.
//   - Field positions of the 8-bit result bus {hidden_act[3:0], ready, class[2:0]}
//   - UART transmitter state encoding and frame data width
//   - Per-class statistics counter width and its saturating increment
//   Optional feature macro used by the reporter: BNN_REPORT_STATS_EN.
// -----------------------------------------------------------------------------
package bnn_pkg;

    // Result bus layout
    localparam int RES_W   = 8;
    localparam int CLS_LSB = 0;
    localparam int CLS_W   = 3;
    localparam int RDY_BIT = 3;
    localparam int HID_LSB = 4;
    localparam int HID_W   = 4;

    // UART framing
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Per-class statistics counters
    localparam int STAT_W = 8;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/bnn_result_uart_reporter_if.sv
// -----------------------------------------------------------------------------
// bnn_result_uart_reporter_if
//   Groups the reporter's bus-level signals.
//   res_bus     classifier result bus {hidden_act, ready, class}
//   clr_ovf     one-cycle pulse clearing the sticky overflow flag
//   tx          UART serial line, idles high
//   tx_busy     high while a frame is on the line
//   fifo_count  current FIFO occupancy, $clog2(DEPTH)+1 bits
//   overflow    sticky flag, a capture was dropped on a full FIFO
//   Modports: master = classifier/host side, slave = reporter.
//   DEPTH must match the reporter's DEPTH parameter.
// -----------------------------------------------------------------------------
interface bnn_result_uart_reporter_if
    import bnn_pkg::*;
#(
    parameter int DEPTH = 4
) ();

    logic [RES_W-1:0]        res_bus;
    logic                    clr_ovf;
    logic                    tx;
    logic                    tx_busy;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    overflow;

    modport master (
        output res_bus, clr_ovf,
        input  tx, tx_busy, fifo_count, overflow
    );

    modport slave (
        input  res_bus, clr_ovf,
        output tx, tx_busy, fifo_count, overflow
    );

endinterface

// File: rtl/bnn_uart_tx.sv
// -----------------------------------------------------------------------------
// bnn_uart_tx
//   8N1 UART transmitter: owns the frame FSM, baud counter and shift register.
//   Ports:
//     clk, rst  clock and synchronous active-high reset
//     ena       clock enable; all state holds while low
//     load      accept data; only honoured in IDLE or on the last STOP cycle
//     data      byte to send, LSB first
//     busy      high whenever a frame is in progress (state != IDLE)
//     done      high during the last clock of the STOP bit
//     tx        registered serial output, idles high
// -----------------------------------------------------------------------------
module bnn_uart_tx
    import bnn_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic                      load,
    input  logic [UART_DATA_BITS-1:0] data,
    output logic                      busy,
    output logic                      done,
    output logic                      tx
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(UART_DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    tx_state_e                 state, state_next;
    logic [BAUD_W-1:0]         baud_cnt, baud_next;
    logic [BIT_W-1:0]          bit_cnt, bit_next;
    logic [UART_DATA_BITS-1:0] shreg, shreg_next;
    logic                      tx_q, tx_next;
    logic                      baud_end;

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign busy     = (state != TX_IDLE);
    // Kept outside the FSM block so the caller's load (which depends on done)
    // does not form a loop through one process.
    assign done     = (state == TX_STOP) && baud_end;
    assign tx       = tx_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else if (ena) begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shreg    <= shreg_next;
            tx_q     <= tx_next;
        end
    end

    // tx is registered: tx_next is the line level for the cycle after the edge.
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shreg_next = shreg;
        tx_next    = tx_q;

        unique case (state)
            TX_IDLE: begin
                tx_next = 1'b1;
                if (load) begin
                    shreg_next = data;
                    baud_next  = '0;
                    state_next = TX_START;
                    tx_next    = 1'b0;
                end
            end

            TX_START: begin
                if (baud_end) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = TX_DATA;
                    tx_next    = shreg[0];
                end else begin
                    baud_next = baud_cnt + BAUD_ONE;
                end
            end

            TX_DATA: begin
                if (baud_end) begin
                    baud_next  = '0;
                    shreg_next = shreg >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        state_next = TX_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next = bit_cnt + BIT_ONE;
                        tx_next  = shreg[1];
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_ONE;
                end
            end

            TX_STOP: begin
                if (baud_end) begin
                    if (load) begin
                        // Back-to-back frame: skip IDLE, start bit follows stop bit.
                        shreg_next = data;
                        baud_next  = '0;
                        state_next = TX_START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = TX_IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_ONE;
                end
            end

            default: begin
                state_next = TX_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/bnn_result_uart_reporter.sv
// -----------------------------------------------------------------------------
// bnn_result_uart_reporter
//   Consumer end of the BNN classifier result bus. Captures one result per
//   rising edge of the ready bit, buffers it in a DEPTH-entry FIFO and sends
//   it off-chip as 8N1 UART frames.
//   Ports:
//     clk, rst  clock and synchronous active-high reset
//     ena       clock enable; all state (and the tx level) holds while low
//     bus       slave side of bnn_result_uart_reporter_if
//               (res_bus, clr_ovf in; tx, tx_busy, fifo_count, overflow out)
//   Macro BNN_REPORT_STATS_EN: when defined, keeps saturating 8-bit counters
//   for class==0 and class!=0; each entry carries {count, result} and is sent
//   as two frames (result byte, then count byte).
//   DEPTH must be a power of two (2..16) and match the interface's DEPTH.
// -----------------------------------------------------------------------------
module bnn_result_uart_reporter
    import bnn_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    bnn_result_uart_reporter_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);

`ifdef BNN_REPORT_STATS_EN
    localparam int ENTRY_W = RES_W + STAT_W;
`else
    localparam int ENTRY_W = RES_W;
`endif

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic                      rdy_q;
    logic                      rise, push_req, push_ok, drop, pop;
    logic                      empty, full;
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic [PTR_W:0]            count;
    logic                      ovf_q;
    logic [ENTRY_W-1:0]        mem [DEPTH];
    logic [ENTRY_W-1:0]        wr_data, head;

    logic                      tx_line, tx_busy, tx_done, tx_load, tx_free;
    logic [UART_DATA_BITS-1:0] tx_data;

    // ---------------- capture ----------------
    assign rise     = bus.res_bus[RDY_BIT] & ~rdy_q;
    assign push_req = ena & rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q <= 1'b0;
        end else if (ena) begin
            rdy_q <= bus.res_bus[RDY_BIT];
        end
    end

    // ---------------- FIFO ----------------
    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign head    = mem[rd_ptr];
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok = push_req & (~full | pop);
    assign drop    = push_req & full & ~pop;

    // The transmitter can take a new byte when idle or on its last stop cycle.
    assign tx_free = ~tx_busy | tx_done;

    // NOTE: the storage array has no reset; occupancy and pointers define
    // which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a new drop on the same edge as clr_ovf wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (ena) begin
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

`ifdef BNN_REPORT_STATS_EN
    // ---------------- per-class statistics ----------------
    logic [STAT_W-1:0]         cnt_zero, cnt_other, cnt_next;
    logic                      is_zero;
    logic                      pend_valid;
    logic [UART_DATA_BITS-1:0] pend_byte;

    assign is_zero  = (bus.res_bus[CLS_LSB +: CLS_W] == '0);
    // The entry carries the count after this capture has been counted.
    assign cnt_next = is_zero ? sat_inc(cnt_zero) : sat_inc(cnt_other);
    assign wr_data  = {cnt_next, bus.res_bus};

    // While the count byte of the current entry is pending, the next stop
    // cycle loads it instead of popping a new entry.
    assign pop      = ena & ~empty & tx_free & ~pend_valid;
    assign tx_load  = pop | (ena & pend_valid & tx_done);
    assign tx_data  = pend_valid ? pend_byte : head[UART_DATA_BITS-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_zero   <= '0;
            cnt_other  <= '0;
            pend_valid <= 1'b0;
            pend_byte  <= '0;
        end else begin
            // Dropped captures are counted too: this follows push_req, not push_ok.
            if (push_req) begin
                if (is_zero) begin
                    cnt_zero <= cnt_next;
                end else begin
                    cnt_other <= cnt_next;
                end
            end
            if (pop) begin
                pend_valid <= 1'b1;
                pend_byte  <= head[ENTRY_W-1 -: STAT_W];
            end else if (ena && pend_valid && tx_done) begin
                pend_valid <= 1'b0;
            end
        end
    end
`else
    assign wr_data = bus.res_bus;
    assign pop     = ena & ~empty & tx_free;
    assign tx_load = pop;
    assign tx_data = head;
`endif

    // ---------------- transmitter ----------------
    bnn_uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .load (tx_load),
        .data (tx_data),
        .busy (tx_busy),
        .done (tx_done),
        .tx   (tx_line)
    );

    assign bus.tx         = tx_line;
    assign bus.tx_busy    = tx_busy;
    assign bus.fifo_count = count;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_bnn_result_uart_reporter.sv
// -----------------------------------------------------------------------------
// tb_bnn_result_uart_reporter
//   Self-checking bench for bnn_result_uart_reporter (DEPTH=4, CLKS_PER_BIT=4).
//   A reference model (queue of entries plus a frame timer) predicts occupancy,
//   overflow, busy and the tx line each cycle, and pushes every byte it expects
//   on the line into a scoreboard; a UART receiver pops and compares frames.
//   Honours BNN_REPORT_STATS_EN when defined.
// -----------------------------------------------------------------------------
module tb_bnn_result_uart_reporter;

    localparam int DEPTH = 4;
    localparam int CPB   = 4;
`ifdef BNN_REPORT_STATS_EN
    localparam int NFR = 2;
`else
    localparam int NFR = 1;
`endif
    localparam int FRAME_CYC = 10 * CPB;
    localparam int ENTRY_CYC = FRAME_CYC * NFR;

    typedef struct packed {
        logic [7:0] cnt;
        logic [7:0] res;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b1;

    bnn_result_uart_reporter_if #(.DEPTH(DEPTH)) bus_if ();

    bnn_result_uart_reporter #(
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    ent_t       mq[$];
    logic [7:0] exp_q[$];
    ent_t       m_cur;
    int         m_timer    = 0;
    logic       m_rdy      = 1'b0;
    logic       m_ovf      = 1'b0;
    int         m_c0       = 0;
    int         m_cn       = 0;
    logic       m_in_reset = 1'b0;
    logic       m_started  = 1'b0;
    logic       m_ena_last = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_timer    = 0;
            m_rdy      = 1'b0;
            m_ovf      = 1'b0;
            m_c0       = 0;
            m_cn       = 0;
            m_in_reset = 1'b1;
            m_started  = 1'b1;
            m_ena_last = 1'b0;
        end else begin
            m_in_reset = 1'b0;
            m_ena_last = ena;
            if (ena) begin
                logic do_pop, rise;
                ent_t e;
                do_pop = (m_timer <= 1) && (mq.size() > 0);
                rise   = bus_if.res_bus[3] && !m_rdy;
                m_rdy  = bus_if.res_bus[3];
                if (do_pop) begin
                    m_cur   = mq.pop_front();
                    m_timer = ENTRY_CYC;
                    exp_q.push_back(m_cur.res);
                    if (NFR == 2) exp_q.push_back(m_cur.cnt);
                end else if (m_timer > 0) begin
                    m_timer--;
                end
                if (bus_if.clr_ovf) m_ovf = 1'b0;
                if (rise) begin
                    if (bus_if.res_bus[2:0] == 3'd0) begin
                        m_c0 = (m_c0 < 255) ? m_c0 + 1 : 255;
                        e.cnt = 8'(m_c0);
                    end else begin
                        m_cn = (m_cn < 255) ? m_cn + 1 : 255;
                        e.cnt = 8'(m_cn);
                    end
                    if (NFR == 1) e.cnt = 8'h00;
                    e.res = bus_if.res_bus;
                    if (mq.size() < DEPTH) mq.push_back(e);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    // Expected line level from the frame position within the current entry.
    function automatic logic exp_tx();
        int pos, fr, bi;
        logic [7:0] b;
        if (m_timer == 0) return 1'b1;
        pos = ENTRY_CYC - m_timer;
        fr  = pos / FRAME_CYC;
        bi  = (pos % FRAME_CYC) / CPB;
        b   = (fr == 0) ? m_cur.res : m_cur.cnt;
        if (bi == 0) return 1'b0;
        if (bi == 9) return 1'b1;
        return b[bi-1];
    endfunction

    // ---------------- per-cycle state checks ----------------
    int peak = 0;

    always @(negedge clk) begin
        if (m_started) begin
            check("tx_line",    bus_if.tx,         exp_tx());
            check("tx_busy",    bus_if.tx_busy,    (m_timer > 0));
            check("fifo_count", bus_if.fifo_count, mq.size());
            check("overflow",   bus_if.overflow,   m_ovf);
            if (int'(bus_if.fifo_count) > peak) peak = int'(bus_if.fifo_count);
        end
    end

    // ---------------- UART receiver / scoreboard ----------------
    logic       rx_active = 1'b0;
    int         rx_n      = 0;
    logic [7:0] rx_byte   = '0;
    logic [7:0] rx_last   = '0;
    int         rx_frames = 0;

    always @(negedge clk) begin
        if (m_in_reset || !m_started) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (bus_if.tx === 1'b0) begin
                rx_active = 1'b1;
                rx_n      = 0;
            end
        end else if (m_ena_last) begin
            rx_n++;
            if ((rx_n % CPB) == CPB / 2) begin
                if (rx_n / CPB >= 1 && rx_n / CPB <= 8) begin
                    rx_byte[rx_n / CPB - 1] = bus_if.tx;
                end else if (rx_n / CPB == 9) begin
                    rx_active = 1'b0;
                    rx_frames++;
                    rx_last = rx_byte;
                    check("stop_bit", bus_if.tx, 1'b1);
                    check("frame_expected", (exp_q.size() > 0), 1'b1);
                    if (exp_q.size() > 0) check("frame_byte", rx_byte, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] v);
        @(negedge clk) bus_if.res_bus = v | 8'h08;
        @(negedge clk) bus_if.res_bus = v & 8'hF7;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((mq.size() != 0 || m_timer != 0 || rx_active) && n < budget) begin
            step(1);
            n++;
        end
        check("drain_in_budget", (n < budget), 1'b1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        bus_if.res_bus = 8'h00;
        bus_if.clr_ovf = 1'b0;

        // 1. reset
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        check("rst_tx",         bus_if.tx,         1'b1);
        check("rst_busy",       bus_if.tx_busy,    1'b0);
        check("rst_fifo_count", bus_if.fifo_count, 0);
        check("rst_overflow",   bus_if.overflow,   1'b0);

        // 2. single capture, tx falls one edge after capture
        @(negedge clk) bus_if.res_bus = 8'h21;
        @(negedge clk) bus_if.res_bus = 8'hA9;
        @(negedge clk) bus_if.res_bus = 8'h21;
        check("t2_count_after_capture", bus_if.fifo_count, 1);
        check("t2_tx_before_pop",       bus_if.tx,         1'b1);
        step(1);
        check("t2_tx_start",            bus_if.tx,         1'b0);
        check("t2_busy_start",          bus_if.tx_busy,    1'b1);
        drain(200);

        // 3. ready held high: a single capture
        f0   = rx_frames;
        peak = 0;
        @(negedge clk) bus_if.res_bus = 8'h58;
        step(100);
        bus_if.res_bus = 8'h50;
        drain(200);
        check("t3_frames", rx_frames - f0, NFR);
        check("t3_peak",   peak,           1);

        // 4. burst of six captures during one frame
        f0 = rx_frames;
        for (int i = 0; i < 6; i++) pulse(8'((i + 1) << 4) | 8'h02);
        check("t4_overflow_set", bus_if.overflow, 1'b1);
        drain(2000);
        check("t4_frames", rx_frames - f0, 5 * NFR);
        @(negedge clk) bus_if.clr_ovf = 1'b1;
        @(negedge clk) bus_if.clr_ovf = 1'b0;
        check("t4_overflow_clr", bus_if.overflow, 1'b0);

        // random traffic with clock-enable gaps and clear pulses
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ena            = ($urandom_range(0, 9) != 0);
            bus_if.res_bus = 8'($urandom);
            bus_if.clr_ovf = ($urandom_range(0, 49) == 0);
        end
        @(negedge clk);
        ena            = 1'b1;
        bus_if.res_bus = 8'h00;
        bus_if.clr_ovf = 1'b0;
        drain(4000);

        // 5. reset during data bit 3 of a frame, with a second entry queued
        pulse(8'h1B);
        pulse(8'h2B);
        step(15);
        rst = 1'b1;
        step(1);
        check("t5_tx",         bus_if.tx,         1'b1);
        check("t5_busy",       bus_if.tx_busy,    1'b0);
        check("t5_fifo_count", bus_if.fifo_count, 0);
        rst = 1'b0;
        f0  = rx_frames;
        step(200);
        check("t5_no_frames", rx_frames - f0, 0);

`ifdef BNN_REPORT_STATS_EN
        // 6. per-class counters
        for (int i = 0; i < 3; i++) begin
            pulse(8'h01);
            drain(400);
        end
        for (int i = 0; i < 300; i++) pulse(8'h00);
        drain(2000);
        check("t6_last_count", rx_last, 8'hFF);
`endif

        step(5);
        check("leftover_frames", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
